// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller: load-use stall, memory freeze, branch flush, memory-wait watchdog.
// Optional event counters are enabled by defining HAZARD_STATS_EN.

`ifndef REG_ADDR
`define REG_ADDR [4:0]
`endif

module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic `REG_ADDR if_id_src1,
  input  logic `REG_ADDR if_id_src2,
  input  logic           if_id_uses_src2,
  input  logic           id_ex_memread,
  input  logic `REG_ADDR id_ex_dest_reg,
  input  logic           branch_taken,
  input  logic           dmem_req,
  input  logic           dmem_ready,
  output logic           pc_write,
  output logic           if_id_write,
  output logic           if_id_flush,
  output logic           id_ex_bubble,
  output logic           pipe_write,
`ifdef HAZARD_STATS_EN
  output logic [31:0]    load_use_count,
  output logic [31:0]    mem_stall_count,
  output logic [31:0]    flush_count,
`endif
  output logic           mem_timeout
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CMP = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic mem_stall;
  logic load_use;
  logic src1_hit;
  logic src2_hit;
  logic flush_case;
  logic load_use_case;

  // Hazard detection: a load into r0 never creates a dependency.
  assign mem_stall = dmem_req & ~dmem_ready;
  assign src1_hit  = (id_ex_dest_reg == if_id_src1);
  assign src2_hit  = if_id_uses_src2 & (id_ex_dest_reg == if_id_src2);
  assign load_use  = id_ex_memread & (id_ex_dest_reg != '0) & (src1_hit | src2_hit);

  assign flush_case    = ~mem_stall & branch_taken;
  assign load_use_case = ~mem_stall & ~branch_taken & load_use;

  // Fixed-priority pipeline control: freeze > flush > load-use stall > run.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_write   = 1'b1;
    if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_write  = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Memory-wait tracker and sticky watchdog; does not feed the control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_stall && (wait_cnt == TIMEOUT_CMP)) begin
        mem_timeout <= 1'b1;
      end
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Event counters, one per active priority case; wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_use_count  <= '0;
      mem_stall_count <= '0;
      flush_count     <= '0;
    end else begin
      if (load_use_case) load_use_count  <= load_use_count + 32'd1;
      if (mem_stall)     mem_stall_count <= mem_stall_count + 32'd1;
      if (flush_case)    flush_count     <= flush_count + 32'd1;
    end
  end
`else
  logic unused_cases;
  assign unused_cases = flush_case ^ load_use_case;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a cycle-level reference model and literal expectations.

module tb_hazard_stall_unit;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] if_id_src1 = '0;
  logic [4:0] if_id_src2 = '0;
  logic       if_id_uses_src2 = 1'b0;
  logic       id_ex_memread = 1'b0;
  logic [4:0] id_ex_dest_reg = '0;
  logic       branch_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0] load_use_count, mem_stall_count, flush_count;
`endif

  hazard_stall_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_uses_src2(if_id_uses_src2),
    .id_ex_memread(id_ex_memread), .id_ex_dest_reg(id_ex_dest_reg),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_write(pipe_write),
`ifdef HAZARD_STATS_EN
    .load_use_count(load_use_count), .mem_stall_count(mem_stall_count), .flush_count(flush_count),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  fails  = 0;
  bit  armed  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: consecutive stall run length, sticky watchdog, event tallies.
  int unsigned run_len = 0;
  bit          to_m = 1'b0;
  int unsigned n_lu = 0, n_ms = 0, n_fl = 0;

  function automatic bit stall_now();
    return dmem_req && !dmem_ready;
  endfunction

  function automatic bit hazard_now();
    return id_ex_memread && (id_ex_dest_reg != 5'd0) &&
           ((id_ex_dest_reg == if_id_src1) || (if_id_uses_src2 && (id_ex_dest_reg == if_id_src2)));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write}
  function automatic logic [4:0] model_out();
    if (stall_now())    return 5'b00000;
    if (branch_taken)   return 5'b11111;
    if (hazard_now())   return 5'b00011;
    return 5'b11001;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      run_len <= 0;
      to_m    <= 1'b0;
      n_lu <= 0; n_ms <= 0; n_fl <= 0;
    end else begin
      run_len <= stall_now() ? run_len + 1 : 0;
      to_m    <= to_m | (stall_now() && (run_len + 1 >= TO));
      if (stall_now()) n_ms <= n_ms + 1;
      else if (branch_taken) n_fl <= n_fl + 1;
      else if (hazard_now()) n_lu <= n_lu + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_ctrl", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write}),
            32'(model_out()));
      check("model_wait_cnt", 32'(dut.wait_cnt), (run_len > 65535) ? 32'd65535 : 32'(run_len));
      check("model_timeout", 32'(mem_timeout), 32'(to_m));
`ifdef HAZARD_STATS_EN
      check("model_lu_count", load_use_count, 32'(n_lu));
      check("model_ms_count", mem_stall_count, 32'(n_ms));
      check("model_fl_count", flush_count, 32'(n_fl));
`endif
    end
  end

  task automatic apply(input string nm, input logic rst, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic mr, input logic [4:0] d, input logic br,
                       input logic rq, input logic rd, input logic [4:0] exp_o,
                       input int exp_cnt, input logic exp_to);
    @(posedge clk);
    #1;
    reset = rst; if_id_src1 = s1; if_id_src2 = s2; if_id_uses_src2 = u2;
    id_ex_memread = mr; id_ex_dest_reg = d; branch_taken = br;
    dmem_req = rq; dmem_ready = rd;
    @(negedge clk);
    check({nm, "_ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_write}), 32'(exp_o));
    check({nm, "_cnt"}, 32'(dut.wait_cnt), 32'(exp_cnt));
    check({nm, "_to"}, 32'(mem_timeout), 32'(exp_to));
  endtask

  initial begin
    @(posedge clk);
    armed = 1'b1;
    //     name          rst s1 s2 u2 mr d  br rq rd exp       cnt to
    apply("rst_idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("lu_rs",       0, 5, 0, 0, 1, 5, 0, 0, 0, 5'b00011, 0, 0);
    apply("lu_done",     0, 5, 0, 0, 0, 5, 0, 0, 0, 5'b11001, 0, 0);
    apply("lu_r0",       0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("rt_unused",   0, 3, 7, 0, 1, 7, 0, 0, 0, 5'b11001, 0, 0);
    apply("rt_used",     0, 3, 7, 1, 1, 7, 0, 0, 0, 5'b00011, 0, 0);
    apply("mw1",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0);
    apply("mw2",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 1, 0);
    apply("mw3",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2, 0);
    apply("mw_ready",    0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11001, 3, 0);
    apply("mw_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("prio_freeze", 0, 5, 0, 0, 1, 5, 1, 1, 0, 5'b00000, 0, 0);
    apply("prio_flush",  0, 5, 0, 0, 1, 5, 1, 1, 1, 5'b11111, 1, 0);
    apply("req_drop_lu", 0, 5, 0, 0, 1, 5, 0, 0, 0, 5'b00011, 0, 0);
    apply("idle2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("wd1",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0);
    apply("wd2",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 1, 0);
    apply("wd3",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2, 0);
    apply("wd4",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 3, 0);
    apply("wd_ready",    0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11001, 4, 1);
    apply("wd_sticky",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 1);
    apply("wd_rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 1);
    apply("wd_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    apply("rm1",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0);
    apply("rm2",         0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 1, 0);
    apply("rm_rst",      1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2, 0);
    apply("rm_re1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 0);
    apply("rm_re2",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 1, 0);
    apply("rm_re3",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 2, 0);
    apply("rm_re4",      0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 3, 0);
    apply("rm_drop",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 4, 1);
    apply("rm_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 1);
    apply("branch_only", 0, 9, 9, 1, 0, 9, 1, 0, 0, 5'b11111, 0, 1);
    apply("rst_lu",      1, 6, 0, 0, 1, 6, 0, 0, 0, 5'b00011, 0, 1);
    apply("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0);
    @(posedge clk);
    #1;
    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
